tft_spi_arbiter: RTL and testbench
==================================

# tft_spi_arbiter

Shares the single `tft_spi` byte transmitter among several drawing engines (`tft_init`, `scene_exhibitor`, `player`, future overlays) with a request/grant handshake. It replaces the hard-wired enable-priority mux at the top level. Ownership is held for a whole frame of bytes and released only after the SPI shift register has drained. The top-level sequencer then only raises requests, with no mux bookkeeping.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8; index 0 is highest fixed priority.
- `IDX_W`, `$clog2(NUM_REQ)`: width of the owner index.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous, active-low.
- `req`  in  NUM_REQ  per-requester hold-request; held high for the whole frame.
- `req_data`  in  8*NUM_REQ  byte per requester; slice i = `[8*i+7:8*i]`.
- `req_dc`  in  NUM_REQ  data/command flag per requester.
- `req_transmit`  in  NUM_REQ  one-cycle byte strobe per requester.
- `grant`  out  NUM_REQ  one-hot current owner, registered.
- `req_busy`  out  NUM_REQ  busy seen by each requester.
- `spi_busy`  in  1  busy from `tft_spi`.
- `spi_data`  out  8  byte to `tft_spi`.
- `spi_dc`  out  1  dc to `tft_spi`.
- `spi_transmit`  out  1  strobe to `tft_spi`.
- `owner`  out  IDX_W  index of the current owner; valid when `owner_valid` is high.
- `owner_valid`  out  1  high in GRANT.
- `err`  out  1  sticky flag: a non-owner pulsed `req_transmit`.

## Operation
State machine in `tft_pkg::arb_state_t`, with states IDLE, GRANT and DRAIN.

- **IDLE**
  - If `|req`, the pick logic selects the winner. On the next edge: `grant` becomes the winner's one-hot, `owner` is set, state goes to GRANT.
  - If no requests, stay in IDLE.
- **GRANT**
  - `spi_data`, `spi_dc` and `spi_transmit` are combinationally muxed from the owner's slice.
  - `req_busy[owner] = spi_busy`. Every other `req_busy` bit is 1.
  - When `req[owner]` is low, on the next edge: `grant` goes to 0 and state goes to DRAIN.
  - A `req_transmit[owner]` in the same cycle as the release is still forwarded.
- **DRAIN**
  - No byte is forwarded and all `req_busy` bits are 1.
  - Go to IDLE on the first edge where `spi_busy` is 0.
- **Non-owner strobes**: any `req_transmit[i]` with `grant[i]` low, in any state, is dropped and sets `err`.
- **Reset values**: state IDLE, `grant` 0, `owner` 0, `owner_valid` 0, `err` 0, round-robin pointer 0.
  - Outputs derived from state follow it: `spi_transmit` 0, `spi_data` 0, `spi_dc` 0, `req_busy` all 1.
  - Reset asserted mid-frame aborts immediately. The byte already inside `tft_spi` is not recalled.
- **Requests during GRANT/DRAIN**: held pending. Nothing is queued beyond the `req` level.
- **Owner strobing while `spi_busy`**: the strobe is forwarded unchanged. Obeying busy is the requester's duty; `tft_spi` decides.

## Timing
- Request to grant: `req` rises at cycle 0 in IDLE → `grant` is high at cycle 1. The first byte can be forwarded at cycle 1.
- Release to next grant: `req` falls at cycle k → DRAIN at k+1.
  - If `spi_busy` is already low at k+1, state is IDLE at k+2 and the next owner is granted at k+3.
  - So there are at least 2 dead cycles between owners.
- Data path to `tft_spi`: zero cycles (combinational from registered `grant`). No bubble is added per byte.
- `err` rises one cycle after the offending strobe.

## Configuration
- `TFT_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at `(last_owner+1) mod NUM_REQ`.
  - The pointer updates on each grant.
- `TFT_ARB_RR_EN` undefined: fixed priority, lowest index wins.
  - The pointer register is not built.
  - Init at index 0 always pre-empts later frames at frame boundaries.

## Structure
- `tft_pkg` holds:
  - `arb_state_t` enum (IDLE/GRANT/DRAIN);
  - `TFT_BYTE_W = 8`;
  - `TFT_MAX_REQ = 8`.
- The sub-module `arb_pick` is natural:
  - combinational; inputs are `req` and the pointer;
  - outputs are the one-hot winner and its index;
  - holds both the round-robin and fixed-priority variants under the macro.
- The FSM, mux, busy fan-out and `err` live in `tft_spi_arbiter`.

## Test plan
- **Single frame**: `req[1]` high at c0; 3 strobes with bytes 0x2A,0x00,0x3F (dc=0,1,1) while `spi_busy` is modelled; `req[1]` low. → `grant`=0010 at c1; `spi_data` matches each byte in order; only `req_busy[1]` tracks `spi_busy`; IDLE after `spi_busy` falls.
- **Simultaneous requests**: `req`=1011 at c0. → fixed priority: grant order 0,1,3. With `TFT_ARB_RR_EN` and pointer after owner 2: order 3,0,1.
- **Drain hold**: release while `spi_busy` stays high for 20 cycles. → state holds DRAIN for 20 cycles; `req[2]` pending is granted exactly 2 cycles after `spi_busy` falls.
- **Intruder strobe**: `req_transmit[3]` pulses with 0xFF while owner is 0. → `spi_transmit` stays 0; `err`=1 next cycle and stays 1 until reset.
- **Reset mid-frame**: `rst` low asynchronously during GRANT. → within the same cycle `grant`=0, `spi_transmit`=0, `req_busy` all 1; after release the highest-priority pending request is granted 1 cycle later.

Source files
------------

// File: rtl/tft_pkg.sv
// tft_pkg: shared types and constants for the TFT SPI arbiter slice.
package tft_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_t;
    localparam int TFT_BYTE_W = 8;
    localparam int TFT_MAX_REQ = 8;
endpackage

// File: rtl/tft_spi_arbiter_pick.sv
// arb_pick: combinational winner selection; TFT_ARB_RR_EN selects round-robin from ptr, else lowest index wins.
module arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx
);
`ifdef TFT_ARB_RR_EN
    // Scan from the far end so the candidate closest to ptr is assigned last.
    always_comb begin
        win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NUM_REQ]) win_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    always_comb begin
        win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[k]) win_idx = IDX_W'(k);
    end
`endif
    assign win = |req ? NUM_REQ'(1) << win_idx : '0;
endmodule

// File: rtl/tft_spi_arbiter.sv
// tft_spi_arbiter: frame-granular request/grant sharing of one tft_spi byte transmitter.
// Define TFT_ARB_RR_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module tft_spi_arbiter
    import tft_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [TFT_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_dc,
    input  logic [NUM_REQ-1:0]            req_transmit,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            req_busy,
    input  logic                          spi_busy,
    output logic [TFT_BYTE_W-1:0]         spi_data,
    output logic                          spi_dc,
    output logic                          spi_transmit,
    output logic [IDX_W-1:0]              owner,
    output logic                          owner_valid,
    output logic                          err
);
    arb_state_t state;
    logic [NUM_REQ-1:0] win;
    logic [IDX_W-1:0] win_idx, ptr;
    logic fwd;
`ifdef TFT_ARB_RR_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) ptr <= '0;
        else if (state == IDLE && |req) ptr <= IDX_W'((int'(win_idx) + 1) % NUM_REQ);
`else
    assign ptr = '0;
`endif
    arb_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req(req),
        .ptr(ptr),
        .win(win),
        .win_idx(win_idx)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            err <= 1'b0;
        end else begin
            err <= err | (|(req_transmit & ~grant));
            case (state)
                IDLE: if (|req) begin
                    state <= GRANT;
                    grant <= win;
                    owner <= win_idx;
                end
                GRANT: if (!req[owner]) begin
                    state <= DRAIN;
                    grant <= '0;
                end
                DRAIN: if (!spi_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign fwd = state == GRANT;
    assign owner_valid = fwd;
    assign spi_transmit = fwd & req_transmit[owner];
    assign spi_dc = fwd & req_dc[owner];
    assign spi_data = fwd ? req_data[TFT_BYTE_W*owner +: TFT_BYTE_W] : '0;
    // grant is zero outside GRANT, so non-owners and idle/drain all see busy.
    assign req_busy = ~grant | {NUM_REQ{spi_busy}};
endmodule

// File: tb/tb_tft_spi_arbiter.sv
// tb_tft_spi_arbiter: directed and randomized checks of tft_spi_arbiter (default fixed-priority build).
module tb_tft_spi_arbiter;
    localparam int N = 4;
    localparam int IW = 2;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req, req_dc, req_transmit, grant, req_busy;
    logic [8*N-1:0] req_data;
    logic spi_busy, spi_dc, spi_transmit, owner_valid, err;
    logic [7:0] spi_data;
    logic [IW-1:0] owner;
    int checks = 0, errors = 0;
    int m_own, m_last, bcnt;
    bit m_drain, m_err;

    tft_spi_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_dc(req_dc),
        .req_transmit(req_transmit), .grant(grant), .req_busy(req_busy),
        .spi_busy(spi_busy), .spi_data(spi_data), .spi_dc(spi_dc),
        .spi_transmit(spi_transmit), .owner(owner), .owner_valid(owner_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1;
        m_last = 0;
        m_drain = 0;
        m_err = 0;
    endtask

    task automatic check_all();
        logic [N-1:0] eb;
        for (int i = 0; i < N; i++) eb[i] = (i == m_own) ? spi_busy : 1'b1;
        chk("grant", grant, m_own >= 0 ? 32'(1) << m_own : 32'(0));
        chk("owner_valid", owner_valid, m_own >= 0);
        if (m_own >= 0) chk("owner", owner, m_own);
        chk("spi_transmit", spi_transmit, m_own >= 0 ? req_transmit[m_own] : 1'b0);
        chk("spi_data", spi_data, m_own >= 0 ? req_data[8*m_own +: 8] : 8'h00);
        chk("spi_dc", spi_dc, m_own >= 0 ? req_dc[m_own] : 1'b0);
        chk("req_busy", req_busy, eb);
        chk("err", err, m_err);
    endtask

    // One clock: check outputs for the current inputs, advance the frame-level model, emulate tft_spi busy.
    task automatic tick();
        bit fwd;
        #1;
        check_all();
        fwd = m_own >= 0 && req_transmit[m_own];
        for (int j = 0; j < N; j++) if (req_transmit[j] && j != m_own) m_err = 1;
        if (m_own >= 0) begin
            if (!req[m_own]) begin
                m_own = -1;
                m_drain = 1;
            end
        end else if (m_drain) begin
            if (!spi_busy) m_drain = 0;
        end else if (req != 0) begin
            m_own = lowest(req);
            m_last = m_own;
        end
        @(posedge clk);
        #2;
        if (fwd) bcnt = $urandom_range(1, 4);
        else if (bcnt > 0) bcnt--;
        spi_busy = bcnt > 0;
        req_transmit = '0;
    endtask

    task automatic settle();
        for (int i = 0; i < 100 && (m_own >= 0 || m_drain || spi_busy); i++) tick();
        chk("settle_idle", owner_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] sb [3];
        logic [2:0] sdc;
        int order[$];
        int t;
        sb[0] = 8'h2A; sb[1] = 8'h00; sb[2] = 8'h3F;
        sdc = 3'b110;
        rst = 1'b0;
        req = '0; req_dc = '0; req_transmit = '0; req_data = '0;
        spi_busy = 1'b0;
        bcnt = 0;
        model_reset();
        #12;
        check_all();
        chk("rst_owner", owner, 0);
        #10 rst = 1'b1;
        @(posedge clk);
        #2;

        // single frame on requester 1
        req = 4'b0010;
        tick();
        #1 chk("sf_grant", grant, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            while (spi_busy) tick();
            req_data[15:8] = sb[k];
            req_dc[1] = sdc[k];
            req_transmit[1] = 1'b1;
            #1 chk("sf_byte", spi_data, sb[k]);
            tick();
        end
        req = '0;
        tick();
        settle();

        // simultaneous requests 1011
        req = 4'b1011;
        for (int c = 0; c < 80 && order.size() < 3; c++) begin
            tick();
            #1;
            if (owner_valid && (order.size() == 0 || order[$] != int'(owner))) begin
                order.push_back(int'(owner));
                req[owner] = 1'b0;
            end
        end
        chk("order_len", order.size(), 3);
        if (order.size() == 3) begin
            chk("order0", order[0], 0);
            chk("order1", order[1], 1);
            chk("order2", order[2], 3);
        end
        settle();

        // drain hold with req[2] pending
        req = 4'b0001;
        tick();
        req = 4'b0101;
        tick();
        req = 4'b0100;
        tick();
        bcnt = 20;
        spi_busy = 1'b1;
        t = 0;
        while (spi_busy && t < 40) begin
            #1 chk("dh_hold", owner_valid, 1'b0);
            tick();
            t++;
        end
        chk("dh_len", t, 20);
        tick();
        #1 chk("dh_pre", grant, 4'b0000);
        tick();
        #1 chk("dh_grant", grant, 4'b0100);
        req = '0;
        tick();
        settle();

        // randomized traffic, owners only strobe
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (req[i]) begin
                    if (m_own == i && $urandom_range(0, 7) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
            req_data = $urandom;
            req_dc = N'($urandom);
            if (m_own >= 0 && $urandom_range(0, 1) == 1) req_transmit[m_own] = 1'b1;
            tick();
        end
        req = '0;
        tick();
        settle();

        // intruder strobe while requester 0 owns the bus
        req = 4'b0001;
        tick();
        tick();
        req_data[31:24] = 8'hFF;
        req_transmit[3] = 1'b1;
        #1 chk("intr_tx", spi_transmit, 1'b0);
        tick();
        #1 chk("intr_err", err, 1'b1);
        tick();
        tick();
        #1 chk("intr_sticky", err, 1'b1);

        // asynchronous reset mid-frame with requesters 0 and 1 pending
        req = 4'b0011;
        req_transmit[0] = 1'b1;
        #3 rst = 1'b0;
        #1;
        chk("rst_grant0", grant, 4'b0000);
        chk("rst_tx0", spi_transmit, 1'b0);
        chk("rst_busy1", req_busy, 4'b1111);
        chk("rst_err0", err, 1'b0);
        model_reset();
        req_transmit = '0;
        #2 rst = 1'b1;
        tick();
        #1 chk("rst_regrant", grant, 4'b0001);
        req = '0;
        tick();
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
